jt12_kon_ctl: RTL and testbench

Key-on controller and slot sequencer for the envelope generator. It owns the 24-slot time-multiplex counter and the per-slot key-on state. It accepts CPU key-on writes (register 0x28 format) through a ready/write handshake, and it presents the serial `keyon_I` bit and frame `zero` pulse that the EG pipeline consumes slot by slot. Updates are applied atomically at a frame boundary, so the EG never sees a half-applied key-on write within one frame.

---
 rtl/jt12_kon_ctl_pkg.sv | 26 ++
 rtl/jt12_kon_dec.sv | 36 +++
 rtl/jt12_kon_ctl.sv | 82 ++++++++
 tb/tb_jt12_kon_ctl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_kon_ctl_pkg.sv
// Shared slot geometry, operator ordering and channel-code helpers for the jt12 key-on path.
package jt12_kon_ctl_pkg;

    localparam int JT12_SLOTS    = 24;
    localparam int JT12_CHANNELS = 6;

    typedef enum logic [1:0] {
        OP_S1 = 2'd0,
        OP_S2 = 2'd1,
        OP_S3 = 2'd2,
        OP_S4 = 2'd3
    } jt12_op_e;

    // Operator served by each group, group 0 in the low bits: S1, S3, S2, S4.
    localparam logic [7:0] JT12_GRP_ORDER = {OP_S4, OP_S2, OP_S3, OP_S1};

    function automatic logic jt12_ch_valid(input logic [2:0] code);
        return code[1:0] != 2'd3;
    endfunction

    // Channel codes 0-2 map to ch0-2 and 4-6 map to ch3-5.
    function automatic logic [2:0] jt12_ch_index(input logic [2:0] code);
        return code[2] ? ({1'b0, code[1:0]} + 3'd3) : {1'b0, code[1:0]};
    endfunction

endpackage

// File: rtl/jt12_kon_dec.sv
// Combinational decode of a key-on write into a 24-slot update mask and value.
// Invalid channel codes yield an all-zero mask.
module jt12_kon_dec
    import jt12_kon_ctl_pkg::*;
(
    input  logic [2:0]  kon_ch,
    input  logic [3:0]  kon_op,
    output logic [23:0] mask,
    output logic [23:0] val
);

    logic [2:0] ch_idx;
    logic [4:0] slot_idx;
    logic [1:0] op_sel;
    logic [1:0] grp;

    assign ch_idx = jt12_ch_index(kon_ch);

    always_comb begin
        mask     = '0;
        val      = '0;
        slot_idx = '0;
        op_sel   = '0;
        grp      = '0;
        if (jt12_ch_valid(kon_ch)) begin
            for (int g = 0; g < 4; g++) begin
                grp      = 2'(g);
                slot_idx = 5'(g * JT12_CHANNELS) + {2'b00, ch_idx};
                op_sel   = JT12_GRP_ORDER[{grp, 1'b0} +: 2];
                mask[slot_idx] = 1'b1;
                val[slot_idx]  = kon_op[op_sel];
            end
        end
    end

endmodule

// File: rtl/jt12_kon_ctl.sv
// Key-on controller: 24-slot sequencer plus per-slot key-on state, updated from one pending write
// at a frame wrap (or next clk_en edge); kon_ready drops from accept until apply, extra writes set kon_ovf.
module jt12_kon_ctl
    import jt12_kon_ctl_pkg::*;
#(
    parameter int SYNC_FRAME = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       kon_wr,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_op,
    output logic       kon_ready,
    output logic       kon_ovf,
    output logic [2:0] slot_ch,
    output logic [1:0] slot_grp,
    output logic       zero,
    output logic       keyon_I
);

    logic [23:0] kon_st;
    logic [23:0] pend_mask;
    logic [23:0] pend_val;
    logic [23:0] dec_mask;
    logic [23:0] dec_val;
    logic        pend_vld;
    logic [4:0]  slot_idx;
    logic        wrap;
    logic        accept;
    logic        apply;

    jt12_kon_dec u_dec (
        .kon_ch (kon_ch),
        .kon_op (kon_op),
        .mask   (dec_mask),
        .val    (dec_val)
    );

    assign slot_idx = 5'(slot_grp) * 5'(JT12_CHANNELS) + 5'(slot_ch);
    assign wrap     = (slot_ch == 3'd5) && (slot_grp == 2'd3);
    assign accept   = kon_wr && !pend_vld && jt12_ch_valid(kon_ch);
    // A write accepted on the wrap edge is not yet pending, so it waits for the next wrap.
    assign apply    = clk_en && pend_vld && ((SYNC_FRAME == 0) || wrap);

    assign kon_ready = !pend_vld;
    assign zero      = (slot_idx == 5'd0);
    assign keyon_I   = kon_st[slot_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_ch   <= '0;
            slot_grp  <= '0;
            kon_st    <= '0;
            pend_vld  <= 1'b0;
            pend_mask <= '0;
            pend_val  <= '0;
            kon_ovf   <= 1'b0;
        end else begin
            if (clk_en) begin
                if (slot_ch == 3'd5) begin
                    slot_ch  <= '0;
                    slot_grp <= slot_grp + 2'd1;
                end else begin
                    slot_ch <= slot_ch + 3'd1;
                end
            end
            if (apply) begin
                kon_st   <= (kon_st & ~pend_mask) | (pend_val & pend_mask);
                pend_vld <= 1'b0;
            end else if (accept) begin
                pend_vld  <= 1'b1;
                pend_mask <= dec_mask;
                pend_val  <= dec_val;
            end
            if (kon_wr && pend_vld) begin
                kon_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jt12_kon_ctl.sv
// Randomised and directed bench for jt12_kon_ctl (SYNC_FRAME=1) against a slot-array reference model.
module tb_jt12_kon_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       kon_wr;
    logic [2:0] kon_ch;
    logic [3:0] kon_op;
    logic       kon_ready;
    logic       kon_ovf;
    logic [2:0] slot_ch;
    logic [1:0] slot_grp;
    logic       zero;
    logic       keyon_I;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one bit per slot, slot = group*6 + channel.
    bit       m_kon [24];
    bit       m_pend;
    int       m_pch;
    bit [3:0] m_pop;
    bit       m_ovf;
    int       m_slot;
    int       grp_of_op [4] = '{0, 2, 1, 3};

    jt12_kon_ctl #(.SYNC_FRAME(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .kon_wr    (kon_wr),
        .kon_ch    (kon_ch),
        .kon_op    (kon_op),
        .kon_ready (kon_ready),
        .kon_ovf   (kon_ovf),
        .slot_ch   (slot_ch),
        .slot_grp  (slot_grp),
        .zero      (zero),
        .keyon_I   (keyon_I)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 24; i++) m_kon[i] = 1'b0;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            m_slot = 0;
        end else begin
            bit rdy;
            rdy = !m_pend;
            if (kon_wr && !rdy) m_ovf = 1'b1;
            if (clk_en && m_pend && m_slot == 23) begin
                int ch;
                ch = (m_pch >= 4) ? m_pch - 1 : m_pch;
                for (int k = 0; k < 4; k++) m_kon[grp_of_op[k] * 6 + ch] = m_pop[k];
                m_pend = 1'b0;
            end else if (kon_wr && rdy && (kon_ch % 4) != 3) begin
                m_pend = 1'b1;
                m_pch  = int'(kon_ch);
                m_pop  = kon_op;
            end
            if (clk_en) m_slot = (m_slot + 1) % 24;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [3:0] op);
        kon_wr = 1'b1;
        kon_ch = ch;
        kon_op = op;
        tick();
        kon_wr = 1'b0;
    endtask

    task automatic run_to_apply();
        for (int i = 0; i < 30 && m_pend; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b0; kon_wr = 1'b0; kon_ch = '0; kon_op = '0;
        tick();
        tick();
        rst = 1'b0;
        n_chk++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %0b want 1", zero); end
        n_chk++; if (keyon_I !== 1'b0) begin n_fail++; $display("FAIL reset_keyon got %0b want 0", keyon_I); end
        n_chk++; if (kon_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", kon_ready); end
        n_chk++; if (kon_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", kon_ovf); end
        n_chk++; if (slot_ch !== 3'd0 || slot_grp !== 2'd0) begin
            n_fail++; $display("FAIL reset_slot got %0d/%0d want 0/0", slot_grp, slot_ch);
        end
    endtask

    task automatic test_counter();
        int zeros = 0;
        clk_en = 1'b1;
        for (int c = 0; c < 48; c++) begin
            if (zero === 1'b1) zeros++;
            n_chk++; if (zero !== (c % 24 == 0)) begin n_fail++; $display("FAIL ctr_zero c=%0d got %0b want %0b", c, zero, c % 24 == 0); end
            n_chk++; if (slot_ch !== 3'(c % 6) || slot_grp !== 2'((c / 6) % 4)) begin
                n_fail++; $display("FAIL ctr_slot c=%0d got %0d/%0d want %0d/%0d", c, slot_grp, slot_ch, (c / 6) % 4, c % 6);
            end
            n_chk++; if (keyon_I !== 1'b0) begin n_fail++; $display("FAIL ctr_keyon c=%0d got %0b want 0", c, keyon_I); end
            tick();
        end
        n_chk++; if (zeros != 2) begin n_fail++; $display("FAIL ctr_zero_count got %0d want 2", zeros); end
    endtask

    task automatic test_ch1_all_ops();
        clk_en = 1'b1;
        for (int i = 0; i < 24 && m_slot != 5; i++) tick();
        do_write(3'd1, 4'b1111);
        for (int i = 0; i < 24 && m_slot != 0; i++) begin
            n_chk++; if (kon_ready !== 1'b0) begin n_fail++; $display("FAIL ch1_ready_wait slot=%0d got %0b want 0", m_slot, kon_ready); end
            tick();
        end
        n_chk++; if (kon_ready !== 1'b1) begin n_fail++; $display("FAIL ch1_ready_after got %0b want 1", kon_ready); end
        for (int i = 0; i < 24; i++) begin
            n_chk++; if (keyon_I !== (m_slot % 6 == 1)) begin
                n_fail++; $display("FAIL ch1_keyon slot=%0d got %0b want %0b", m_slot, keyon_I, m_slot % 6 == 1);
            end
            tick();
        end
    endtask

    task automatic test_s2_only();
        clk_en = 1'b1;
        do_write(3'd4, 4'b0010);
        run_to_apply();
        for (int i = 0; i < 24; i++) begin
            n_chk++; if (keyon_I !== ((m_slot % 6 == 1) || m_slot == 15)) begin
                n_fail++; $display("FAIL s2_keyon slot=%0d got %0b want %0b", m_slot, keyon_I, (m_slot % 6 == 1) || m_slot == 15);
            end
            tick();
        end
        do_write(3'd4, 4'b0000);
        run_to_apply();
        for (int i = 0; i < 24; i++) begin
            n_chk++; if (keyon_I !== (m_slot % 6 == 1)) begin
                n_fail++; $display("FAIL s2_clear slot=%0d got %0b want %0b", m_slot, keyon_I, m_slot % 6 == 1);
            end
            tick();
        end
    endtask

    task automatic test_invalid_ch();
        logic [2:0] codes [2] = '{3'd3, 3'd7};
        clk_en = 1'b1;
        foreach (codes[j]) begin
            do_write(codes[j], 4'($urandom));
            n_chk++; if (kon_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready code=%0d got %0b want 1", codes[j], kon_ready); end
            n_chk++; if (kon_ovf !== 1'b0) begin n_fail++; $display("FAIL inv_ovf code=%0d got %0b want 0", codes[j], kon_ovf); end
        end
        for (int i = 0; i < 48; i++) begin
            n_chk++; if (keyon_I !== (m_slot % 6 == 1) || kon_ready !== 1'b1) begin
                n_fail++; $display("FAIL inv_state slot=%0d got keyon %0b ready %0b want %0b 1", m_slot, keyon_I, kon_ready, m_slot % 6 == 1);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int r;
        clk_en = 1'b1;
        r = $urandom_range(0, 5);
        kon_wr = 1'b1;
        kon_ch = 3'(r < 3 ? r : r + 1);
        kon_op = 4'($urandom);
        tick();
        kon_ch = 3'd0;
        kon_op = 4'b1111;
        tick();
        kon_wr = 1'b0;
        n_chk++; if (kon_ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf got %0b want 1", kon_ovf); end
        run_to_apply();
        for (int i = 0; i < 48; i++) begin
            n_chk++; if (keyon_I !== m_kon[m_slot]) begin
                n_fail++; $display("FAIL b2b_keyon slot=%0d got %0b want %0b", m_slot, keyon_I, m_kon[m_slot]);
            end
            n_chk++; if (kon_ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf_sticky got %0b want 1", kon_ovf); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            clk_en = ($urandom % 4) != 0;
            kon_wr = ($urandom % 5) == 0;
            kon_ch = 3'($urandom);
            kon_op = 4'($urandom);
            tick();
            n_chk++; if (keyon_I !== m_kon[m_slot]) begin
                n_fail++; $display("FAIL rnd_keyon i=%0d got %0b want %0b", i, keyon_I, m_kon[m_slot]);
            end
            n_chk++; if (slot_ch !== 3'(m_slot % 6) || slot_grp !== 2'(m_slot / 6) || zero !== (m_slot == 0)) begin
                n_fail++; $display("FAIL rnd_slot i=%0d got %0d/%0d z%0b want %0d/%0d", i, slot_grp, slot_ch, zero, m_slot / 6, m_slot % 6);
            end
            n_chk++; if (kon_ready !== !m_pend || kon_ovf !== m_ovf) begin
                n_fail++; $display("FAIL rnd_hs i=%0d got rdy %0b ovf %0b want %0b %0b", i, kon_ready, kon_ovf, !m_pend, m_ovf);
            end
        end
        kon_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        clk_en = 1'b1;
        kon_wr = 1'b0;
        run_to_apply();
        for (int i = 0; i < 24 && m_slot != 23; i++) tick();
        do_write(3'd6, 4'b1111);
        n_chk++; if (kon_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pending got %0b want 0", kon_ready); end
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (zero !== 1'b1 || slot_ch !== 3'd0 || slot_grp !== 2'd0) begin
            n_fail++; $display("FAIL rm_slot got z%0b %0d/%0d want z1 0/0", zero, slot_grp, slot_ch);
        end
        n_chk++; if (kon_ready !== 1'b1 || kon_ovf !== 1'b0) begin
            n_fail++; $display("FAIL rm_hs got rdy %0b ovf %0b want 1 0", kon_ready, kon_ovf);
        end
        for (int i = 0; i < 48; i++) begin
            n_chk++; if (keyon_I !== 1'b0 || kon_ready !== 1'b1) begin
                n_fail++; $display("FAIL rm_state slot=%0d got keyon %0b ready %0b want 0 1", m_slot, keyon_I, kon_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_ch1_all_ops();
        test_s2_only();
        test_invalid_ch();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
